// File: rtl/fp_sched_pkg.sv
// Shared constants and helpers for the add/sub scheduler.
// Operation encodings and per-width sign masks.
package fp_sched_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic logic [63:0] sign_mask(input int width);
    return (width == 64) ? 64'h8000_0000_0000_0000
                         : 64'h0000_0000_8000_0000;
  endfunction

endpackage

// File: rtl/fp_addsub_sched_arb.sv
// Two-way round-robin arbiter; owns the last-grant pointer.
// Pointer moves only when the grant is actually taken.
import fp_sched_pkg::*;

module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last_grant;

  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    unique case (1'b1)
      (req == 2'b11): begin
        gnt_id = ~last_grant;
        gnt    = last_grant ? 2'b01 : 2'b10;
      end
      (req == 2'b01): begin
        gnt_id = 1'b0;
        gnt    = 2'b01;
      end
      (req == 2'b10): begin
        gnt_id = 1'b1;
        gnt    = 2'b10;
      end
      default: begin
        gnt_id = 1'b0;
        gnt    = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant <= 1'b1;
    else if (advance) last_grant <= gnt_id;
  end

endmodule

// File: rtl/fp_addsub_sched_fpadder.sv
// Combinational IEEE-754 adder, round-to-nearest-even.
// Handles subnormals, infinities and NaN (canonical quiet NaN out).
module FPAdder #(
  parameter int BUS_WIDTH = 64
) (
  input  logic [BUS_WIDTH-1:0] A,
  input  logic [BUS_WIDTH-1:0] B,
  output logic [BUS_WIDTH-1:0] out
);

  localparam int EW = (BUS_WIDTH == 64) ? 11 : 8;
  localparam int MW = BUS_WIDTH - EW - 1;
  localparam int SW = MW + 5;
  localparam logic [EW-1:0] EMAX = '1;

  logic sa, sb, sx, sy;
  logic [EW-1:0] ea, eb, ex, ey;
  logic [MW-1:0] fa, fb, fx, fy;
  logic nan_a, nan_b, inf_a, inf_b;
  logic lost, found, up;
  logic [SW-1:0] mx, my, sh, sum, nrm;
  logic [MW+1:0] rnd;
  int xe, ye, dsh, e, lz, shf;

  always_comb begin
    {sa, ea, fa} = A;
    {sb, eb, fb} = B;
    nan_a = (ea == EMAX) && (fa != '0);
    nan_b = (eb == EMAX) && (fb != '0);
    inf_a = (ea == EMAX) && (fa == '0);
    inf_b = (eb == EMAX) && (fb == '0);
    // x is the larger magnitude operand
    if ({eb, fb} > {ea, fa}) begin
      {sx, ex, fx} = B;
      {sy, ey, fy} = A;
    end else begin
      {sx, ex, fx} = A;
      {sy, ey, fy} = B;
    end
    xe = (ex == '0) ? 1 : int'(ex);
    ye = (ey == '0) ? 1 : int'(ey);
    mx = {1'b0, ex != '0, fx, 3'b000};
    my = {1'b0, ey != '0, fy, 3'b000};
    dsh = xe - ye;
    lost = 1'b0;
    if (dsh >= SW) begin
      sh = '0;
      lost = |my;
    end else begin
      sh = my >> dsh;
      lost = (sh << dsh) != my;
    end
    sh[0] = sh[0] | lost;
    sum = (sx == sy) ? mx + sh : mx - sh;
    nrm = sum;
    e = xe;
    lz = 0;
    shf = 0;
    found = 1'b0;
    if (sum[SW-1]) begin
      nrm = {1'b0, sum[SW-1:2], sum[1] | sum[0]};
      e = xe + 1;
    end else begin
      for (int i = SW - 2; i >= 0; i--) begin
        if (!found) begin
          if (nrm[i]) found = 1'b1;
          else lz = lz + 1;
        end
      end
      // never normalise below the minimum exponent
      shf = (lz < e - 1) ? lz : e - 1;
      nrm = nrm << shf;
      e = e - shf;
      if (!nrm[SW-2]) e = 0;
    end
    up = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    rnd = {1'b0, nrm[SW-2:3]} + {{(MW + 1){1'b0}}, up};
    if (rnd[MW+1]) begin
      rnd = rnd >> 1;
      e = e + 1;
    end else if (e == 0 && rnd[MW]) begin
      e = 1;
    end
    if (e >= int'(EMAX)) out = {sx, EMAX, {MW{1'b0}}};
    else out = {sx, EW'(e), rnd[MW-1:0]};
    if (nan_a || nan_b || (inf_a && inf_b && sa != sb))
      out = {1'b0, EMAX, 1'b1, {(MW - 1){1'b0}}};
    else if (inf_a) out = A;
    else if (inf_b) out = B;
    else if (sum == '0) out = {sx & sy, {(BUS_WIDTH - 1){1'b0}}};
  end

endmodule

// File: rtl/fp_addsub_sched.sv
// Two-client add/sub scheduler sharing one FPAdder.
// S1 = operand register, S2 = result register.
import fp_sched_pkg::*;

module fp_addsub_sched #(
  parameter int BUS_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [BUS_WIDTH-1:0] req0_A,
  input  logic [BUS_WIDTH-1:0] req0_B,
  input  logic                 req0_op,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [BUS_WIDTH-1:0] req1_A,
  input  logic [BUS_WIDTH-1:0] req1_B,
  input  logic                 req1_op,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_id,
  output logic [BUS_WIDTH-1:0] res_out,
  output logic                 busy
);

  localparam logic [BUS_WIDTH-1:0] SIGN_MASK =
    BUS_WIDTH'(sign_mask(BUS_WIDTH));

  logic                 s1_valid;
  logic [BUS_WIDTH-1:0] s1_a;
  logic [BUS_WIDTH-1:0] s1_b;
  logic                 s1_id;
  logic                 s2_valid;
  logic [BUS_WIDTH-1:0] s2_out;
  logic                 s2_id;

  logic                 s2_take;
  logic                 s1_move;
  logic                 slot_free;
  logic                 accept;
  logic [1:0]           gnt;
  logic                 gnt_id;
  logic [BUS_WIDTH-1:0] sel_a;
  logic [BUS_WIDTH-1:0] sel_b;
  logic                 sel_op;
  logic [BUS_WIDTH-1:0] b_adj;
  logic [BUS_WIDTH-1:0] sum;

  assign s2_take   = !s2_valid | res_ready;
  assign s1_move   = s1_valid & s2_take;
  assign slot_free = (!s1_valid | s1_move) & !rst;
  assign accept    = slot_free & |gnt;

  assign req0_ready = slot_free & gnt[0];
  assign req1_ready = slot_free & gnt[1];

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_valid, req0_valid}),
    .advance (accept),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  assign sel_a  = gnt_id ? req1_A  : req0_A;
  assign sel_b  = gnt_id ? req1_B  : req0_B;
  assign sel_op = gnt_id ? req1_op : req0_op;

  // subtract is add with B's sign flipped, specials included
  always_comb begin
    b_adj = sel_b;
    unique case (sel_op)
      OP_ADD:  b_adj = sel_b;
      OP_SUB:  b_adj = sel_b ^ SIGN_MASK;
      default: b_adj = sel_b;
    endcase
  end

  FPAdder #(.BUS_WIDTH(BUS_WIDTH)) u_add (
    .A   (s1_a),
    .B   (s1_b),
    .out (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= sel_a;
      s1_b     <= b_adj;
      s1_id    <= gnt_id;
    end else if (slot_free) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_out   <= '0;
      s2_id    <= 1'b0;
    end else if (s1_move) begin
      s2_valid <= 1'b1;
      s2_out   <= sum;
      s2_id    <= s1_id;
    end else if (s2_take) begin
      s2_valid <= 1'b0;
    end
  end

  assign res_valid = s2_valid;
  assign res_out   = s2_out;
  assign res_id    = s2_id;
  assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Directed bench for fp_addsub_sched (64-bit and 32-bit instances).
module tb_fp_addsub_sched;

  localparam logic [63:0] D1  = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] D2  = 64'h4000_0000_0000_0000;
  localparam logic [63:0] DH  = 64'h3FE0_0000_0000_0000;
  localparam logic [63:0] D3  = 64'h4008_0000_0000_0000;
  localparam logic [63:0] D4  = 64'h4010_0000_0000_0000;
  localparam logic [63:0] D15 = 64'h3FF8_0000_0000_0000;
  localparam logic [63:0] DM1 = 64'hBFF0_0000_0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic r0v, r0r, r0op, r1v, r1r, r1op;
  logic [63:0] r0a, r0b, r1a, r1b;
  logic rv, rr, rid, rbusy;
  logic [63:0] rout;

  logic h0v, h0r, h0op, h1v, h1r, h1op;
  logic [31:0] h0a, h0b, h1a, h1b;
  logic hv, hrr, hid, hbusy;
  logic [31:0] hout;

  int n_chk = 0;
  int n_fail = 0;
  int p;
  logic [63:0] got[$];
  logic [63:0] bp_a[3];
  logic [63:0] bp_b[3];
  logic [63:0] bp_r[3];

  fp_addsub_sched #(.BUS_WIDTH(64)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(r0r),
    .req0_A(r0a), .req0_B(r0b), .req0_op(r0op),
    .req1_valid(r1v), .req1_ready(r1r),
    .req1_A(r1a), .req1_B(r1b), .req1_op(r1op),
    .res_valid(rv), .res_ready(rr), .res_id(rid),
    .res_out(rout), .busy(rbusy)
  );

  fp_addsub_sched #(.BUS_WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .req0_valid(h0v), .req0_ready(h0r),
    .req0_A(h0a), .req0_B(h0b), .req0_op(h0op),
    .req1_valid(h1v), .req1_ready(h1r),
    .req1_A(h1a), .req1_B(h1b), .req1_op(h1op),
    .res_valid(hv), .res_ready(hrr), .res_id(hid),
    .res_out(hout), .busy(hbusy)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_bp();
    r0op = 1'b0;
    if (p < 3) begin
      r0v = 1'b1;
      r0a = bp_a[p];
      r0b = bp_b[p];
    end else begin
      r0v = 1'b0;
    end
  endtask

  initial begin
    bp_a = '{D1, D1, D2};
    bp_b = '{D1, D2, D2};
    bp_r = '{D2, D3, D4};
    rst = 1'b1; rr = 1'b1;
    r0v = 1'b1; r0a = D1; r0b = D2; r0op = 1'b0;
    r1v = 1'b1; r1a = D1; r1b = D2; r1op = 1'b0;
    h0v = 1'b0; h0a = '0; h0b = '0; h0op = 1'b0;
    h1v = 1'b0; h1a = '0; h1b = '0; h1op = 1'b0;
    hrr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", rv, 0);
    check("rst_id", rid, 0);
    check("rst_out", rout, 0);
    check("rst_busy", rbusy, 0);
    check("rst_rdy0", r0r, 0);
    check("rst_rdy1", r1r, 0);
    r0v = 1'b0; r1v = 1'b0; rst = 1'b0;
    @(negedge clk);

    r0v = 1'b1; r0a = D1; r0b = D2; r0op = 1'b0;
    #1 check("add_ready", r0r, 1);
    @(negedge clk);
    r0v = 1'b0;
    check("add_s1_only", rv, 0);
    check("add_busy", rbusy, 1);
    @(negedge clk);
    check("add_valid", rv, 1);
    check("add_id", rid, 0);
    check("add_out", rout, D3);
    @(negedge clk);
    check("add_drained", rv, 0);

    r1v = 1'b1; r1a = D1; r1b = D2; r1op = 1'b1;
    #1 check("sub_ready", r1r, 1);
    @(negedge clk);
    r1v = 1'b0;
    @(negedge clk);
    check("sub_valid", rv, 1);
    check("sub_id", rid, 1);
    check("sub_out", rout, DM1);
    @(negedge clk);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    r0v = 1'b1; r0a = D1; r0b = D1; r0op = 1'b0;
    r1v = 1'b1; r1a = D2; r1b = DH; r1op = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("cont_gnt0_%0d", k), r0r, 64'(k % 2 == 0));
      check($sformatf("cont_gnt1_%0d", k), r1r, 64'(k % 2 == 1));
      if (k >= 2) begin
        check($sformatf("cont_valid_%0d", k), rv, 1);
        check($sformatf("cont_id_%0d", k), rid, 64'(k % 2));
        check($sformatf("cont_out_%0d", k), rout,
              (k % 2 == 0) ? D2 : D15);
      end
      @(negedge clk);
    end
    r0v = 1'b0; r1v = 1'b0;
    repeat (3) @(negedge clk);
    check("cont_idle", rbusy, 0);

    rr = 1'b0;
    p = 0;
    for (int k = 0; k < 5; k++) begin
      drive_bp();
      #1;
      if (r0v && r0r) p++;
      if (rv) check($sformatf("bp_hold_%0d", k), rout, D2);
      @(negedge clk);
    end
    check("bp_accepted", 64'(p), 2);
    rr = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive_bp();
      #1;
      if (r0v && r0r) p++;
      if (rv) got.push_back(rout);
      @(negedge clk);
    end
    r0v = 1'b0;
    check("bp_count", 64'(got.size()), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("bp_res_%0d", i),
            (got.size() > i) ? got[i] : 64'hDEAD, bp_r[i]);

    rr = 1'b0;
    r0v = 1'b1; r0a = D1; r0b = D1; r0op = 1'b0;
    #1 check("mid_rdy_a", r0r, 1);
    @(negedge clk);
    r0a = D2; r0b = D2;
    #1 check("mid_rdy_b", r0r, 1);
    @(negedge clk);
    r0v = 1'b0;
    check("mid_full", rv, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_valid", rv, 0);
    check("mid_busy", rbusy, 0);
    rr = 1'b1;
    r0v = 1'b1; r0a = D1; r0b = D1; r0op = 1'b0;
    r1v = 1'b1; r1a = D2; r1b = DH; r1op = 1'b1;
    #1;
    check("mid_gnt0", r0r, 1);
    check("mid_gnt1", r1r, 0);
    @(negedge clk);
    r0v = 1'b0; r1v = 1'b0;
    repeat (3) @(negedge clk);

    h0v = 1'b1; h0a = 32'h3F80_0000; h0b = 32'h4000_0000; h0op = 1'b1;
    #1 check("w32_ready", h0r, 1);
    check("w32_rdy1", h1r, 0);
    @(negedge clk);
    h0v = 1'b0;
    @(negedge clk);
    check("w32_valid", hv, 1);
    check("w32_id", hid, 0);
    check("w32_out", hout, 32'hBF80_0000);
    @(negedge clk);
    check("w32_idle", hbusy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_addsub_sched.md
# fp_addsub_sched

Two-requester scheduler that shares a single combinational `FPAdder` between two clients, each issuing either an add or a subtract. Arbitration is round-robin with a valid/ready handshake on each request port. Subtraction is mapped onto the adder by flipping the sign bit of B. The block sits between the execute-stage issue logic and the FPU, and provides a 2-stage registered pipeline with one result port carrying the requester id.

## Interface
- `BUS_WIDTH`, 64: operand width; only 32 (single) and 64 (double) are legal.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request present on port 0 / 1.
- `req0_ready` / `req1_ready`  out  1  port accepted this cycle (valid && ready).
- `req0_A`, `req0_B` / `req1_A`, `req1_B`  in  BUS_WIDTH  IEEE-754 operands.
- `req0_op` / `req1_op`  in  1  0 = A+B, 1 = A−B.
- `res_valid`  out  1  result held in output register.
- `res_ready`  in  1  consumer takes result when res_valid && res_ready.
- `res_id`  out  1  requester (0/1) that produced the result.
- `res_out`  out  BUS_WIDTH  sum/difference from FPAdder.
- `busy`  out  1  s1_valid | s2_valid.

## Operation
- Pipeline:
  - Stage S1 holds the operand register: s1_valid, s1_A, s1_B (sign already adjusted), s1_id.
  - FPAdder is combinational from S1.
  - Stage S2 holds the result register: s2_valid, s2_out, s2_id.
  - res_* are driven directly from S2.
- Subtract: s1_B = B ^ SIGN_MASK when op=1, else B unmodified.
  - SIGN_MASK = 1 << (BUS_WIDTH−1).
  - Applies to ±0, ±Inf and NaN identically; no special-casing.
  - Adder operands are ordered so the result is A − B.
- Advance rules (all combinational):
  - s2_take = !s2_valid | res_ready.
  - s1_move = s1_valid & s2_take.
  - slot_free = !s1_valid | s1_move.
- Arbitration, using register last_grant (reset 1, so port 0 wins first):
  - Only one port valid: that port is granted.
  - Both valid: the port ≠ last_grant is granted.
  - reqN_ready = slot_free & grant==N. Ready may depend on the other port's valid.
  - last_grant updates only on an accepted request.
- On accept: load S1 with the granted port's A, adjusted B and id.
- On s1_move: load S2 with the adder output and s1_id.
- If s2_take & !s1_move, S2 empties (s2_valid ← 0).
- If slot_free & no accept, s1_valid ← 0.
- Requesters must hold A/B/op stable while valid && !ready. The block does not latch unaccepted requests.

## Timing
- Reset values: s1_valid=0, s2_valid=0, last_grant=1.
  - Outputs: res_valid=0, res_id=0, res_out=0, busy=0.
  - Both readies = 0 during the reset cycle.
- Latency: request accepted at edge N → res_valid=1 after edge N+1, i.e. 2 cycles.
- Throughput is 1 op/cycle with res_ready held high.
- Backpressure (res_ready=0 with S2 full):
  - S2 holds its value.
  - S1 holds its value if full.
  - Both readies drop the cycle after S1 fills; nothing is lost or duplicated.
- Simultaneous res_ready and full S1: S2 is replaced by the S1 result in the same edge, and a new request is accepted into S1 in that same edge.
- Reset mid-operation: in-flight S1/S2 contents are discarded, no result is emitted, and last_grant returns to 1.
- res_out/res_id are stable while res_valid && !res_ready.

## Structure
- Package `fp_sched_pkg`:
  - localparams OP_ADD=1'b0, OP_SUB=1'b1.
  - function sign_mask(width), returning 64'h8000000000000000 or 32'h80000000.
- Sub-module `rr_arbiter2`:
  - Inputs: clk, rst, req[1:0], advance.
  - Outputs: gnt[1:0] (one-hot) and gnt_id.
  - Owns last_grant.
- One instance of the existing `FPAdder #(.BUS_WIDTH(BUS_WIDTH))`.

## Test plan
- Single add, port 0, double (BUS_WIDTH=64):
  - Stimulus: A=3FF0000000000000 (1.0), B=4000000000000000 (2.0), op=0.
  - Response: req0_ready=1 in the cycle it is asserted; 2 cycles later res_valid=1, res_id=0, res_out=4008000000000000 (3.0).
- Subtract, port 1:
  - Stimulus: A=3FF0000000000000, B=4000000000000000, op=1.
  - Response: res_out=BFF0000000000000 (−1.0), res_id=1.
- Contention, both ports valid continuously with res_ready=1, after reset:
  - Port 0 ops: 1.0+1.0. Port 1 ops: 2.0−0.5 (B=3FE0000000000000).
  - Grants alternate 0,1,0,1.
  - Results alternate 4000000000000000 (id 0) and 3FF8000000000000 (id 1), one per cycle.
- Backpressure:
  - Stimulus: res_ready=0 for 5 cycles while port 0 issues 3 ops.
  - Response: exactly 2 ops accepted, res_out stable throughout.
  - On release, remaining results drain in order with no loss or duplicates.
- Reset mid-flight: assert rst with S1 and S2 both full → next cycle res_valid=0, busy=0, and port 0 wins the next contention.
- BUS_WIDTH=32:
  - Stimulus: A=3F800000 (1.0), B=40000000 (2.0), op=1.
  - Response: res_out=BF800000 (−1.0).
